// File: rtl/cpu_control_sequencer_pkg.sv
// Shared definitions for the microcode sequencer of the 8-bit bus CPU.
// Contents:
//   - opcode constants (IR high nibble)
//   - control-word bit positions and one-hot masks
//   - CTRL_IDLE: nothing drives or loads the bus
//   - fetch words for T0 and T1, common to every opcode
//   - last_step(): last non-empty microstep of each opcode
// A control word is kept in pin polarity. Active-low strobes sit at 1 when
// idle, and ce/su sit at 0. XOR-ing CTRL_IDLE with a mask of strobes
// produces the word that asserts exactly those strobes.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CTRL_W = 15;
  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam int C_MI = 0;
  localparam int C_RI = 1;
  localparam int C_RO = 2;
  localparam int C_IO = 3;
  localparam int C_II = 4;
  localparam int C_AI = 5;
  localparam int C_AO = 6;
  localparam int C_EO = 7;
  localparam int C_SU = 8;
  localparam int C_BI = 9;
  localparam int C_OI = 10;
  localparam int C_CE = 11;
  localparam int C_CO = 12;
  localparam int C_J  = 13;
  localparam int C_FI = 14;

  localparam ctrl_t B_MI = ctrl_t'(1) << C_MI;
  localparam ctrl_t B_RI = ctrl_t'(1) << C_RI;
  localparam ctrl_t B_RO = ctrl_t'(1) << C_RO;
  localparam ctrl_t B_IO = ctrl_t'(1) << C_IO;
  localparam ctrl_t B_II = ctrl_t'(1) << C_II;
  localparam ctrl_t B_AI = ctrl_t'(1) << C_AI;
  localparam ctrl_t B_AO = ctrl_t'(1) << C_AO;
  localparam ctrl_t B_EO = ctrl_t'(1) << C_EO;
  localparam ctrl_t B_SU = ctrl_t'(1) << C_SU;
  localparam ctrl_t B_BI = ctrl_t'(1) << C_BI;
  localparam ctrl_t B_OI = ctrl_t'(1) << C_OI;
  localparam ctrl_t B_CE = ctrl_t'(1) << C_CE;
  localparam ctrl_t B_CO = ctrl_t'(1) << C_CO;
  localparam ctrl_t B_J  = ctrl_t'(1) << C_J;
  localparam ctrl_t B_FI = ctrl_t'(1) << C_FI;

  // Every strobe is active-low except ce and su.
  localparam ctrl_t CTRL_IDLE = ~(B_SU | B_CE);

  localparam ctrl_t FETCH_T0 = CTRL_IDLE ^ (B_CO | B_MI);
  localparam ctrl_t FETCH_T1 = CTRL_IDLE ^ (B_RO | B_II | B_CE);

  // Last microstep that can carry work for an opcode. Every opcode is at
  // least 2, so a restart never cuts into fetch. Conditional jumps report 2
  // whether or not they are taken.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    logic [2:0] r;
    case (op)
      OP_LDA, OP_STA: r = 3'd3;
      OP_ADD, OP_SUB: r = 3'd4;
      default:        r = 3'd2;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_step_counter.sv
// T-state step counter.
// Ports:
//   clk     rising-edge clock
//   clr_n   asynchronous active-low clear to 0
//   en      advance enable; the counter holds its value when en is low
//   restart when en is high, the next value is 0 instead of count+1
//   count   current step; wraps from STEPS-1 to 0
module step_counter #(
  parameter int STEPS = 5,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic         restart,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (restart || (count_q == W'(STEPS - 1))) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_control_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU.
// The block holds the T-state counter and a sticky halt flag. It decodes
// (step, opcode, carry, zero) into the control word that steers every bus
// stage. Control outputs are combinational. Consumers latch them at the
// rising edge that ends the current step.
// Ports:
//   clk, clr_n        clock and asynchronous active-low reset
//   step_en           gates counter advance (single-step / run)
//   opcode            IR high nibble
//   carry, zero       flags register outputs, used only by JC/JZ in T2
//   step              current T-state
//   hlt               halt, active-high, sticky until clr_n
//   mi_n .. fi_n, su, ce   control word (see cpu_ctrl_pkg for polarity)
module cpu_control_sequencer #(
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       step_en,
  input  logic [3:0] opcode,
  input  logic       carry,
  input  logic       zero,
  output logic [2:0] step,
  output logic       hlt,
  output logic       mi_n,
  output logic       ri_n,
  output logic       ro_n,
  output logic       io_n,
  output logic       ii_n,
  output logic       ai_n,
  output logic       ao_n,
  output logic       eo_n,
  output logic       su,
  output logic       bi_n,
  output logic       oi_n,
  output logic       ce,
  output logic       co_n,
  output logic       j_n,
  output logic       fi_n
);

  import cpu_ctrl_pkg::*;

  localparam int STEP_W = $clog2(STEPS);

  logic [STEP_W-1:0] cnt;
  logic [2:0]        cur_step;
  logic              halted_d;
  logic              halted_q;
  logic              hlt_t2;
  logic              adv_en;
  logic              restart;
  ctrl_t             ctrl;

  assign cur_step = 3'(cnt);

  // HLT in T2 blocks the advance at the edge that sets halted, so the
  // counter freezes at 2 instead of restarting.
  assign hlt_t2  = clr_n && (cur_step == 3'd2) && (opcode == OP_HLT);
  assign adv_en  = step_en && !halted_q && !hlt_t2;
  assign restart = EARLY_END && (cur_step >= last_step(opcode));

  step_counter #(
    .STEPS (STEPS),
    .W     (STEP_W)
  ) u_step_counter (
    .clk     (clk),
    .clr_n   (clr_n),
    .en      (adv_en),
    .restart (restart),
    .count   (cnt)
  );

  always_comb begin
    halted_d = halted_q;
    if (step_en && hlt_t2) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Once halted, every strobe stays idle. A change on the IR nibble cannot
  // then disturb the bus.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (clr_n && !halted_q) begin
      case (cur_step)
        3'd0: ctrl = FETCH_T0;
        3'd1: ctrl = FETCH_T1;
        3'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = CTRL_IDLE ^ (B_IO | B_MI);
            OP_LDI: ctrl = CTRL_IDLE ^ (B_IO | B_AI);
            OP_JMP: ctrl = CTRL_IDLE ^ (B_IO | B_J);
            OP_JC:  if (carry) ctrl = CTRL_IDLE ^ (B_IO | B_J);
            OP_JZ:  if (zero)  ctrl = CTRL_IDLE ^ (B_IO | B_J);
            OP_OUT: ctrl = CTRL_IDLE ^ (B_AO | B_OI);
            default: ctrl = CTRL_IDLE;
          endcase
        end
        3'd3: begin
          case (opcode)
            OP_LDA:         ctrl = CTRL_IDLE ^ (B_RO | B_AI);
            OP_ADD, OP_SUB: ctrl = CTRL_IDLE ^ (B_RO | B_BI);
            OP_STA:         ctrl = CTRL_IDLE ^ (B_AO | B_RI);
            default:        ctrl = CTRL_IDLE;
          endcase
        end
        3'd4: begin
          case (opcode)
            OP_ADD:  ctrl = CTRL_IDLE ^ (B_EO | B_AI | B_FI);
            OP_SUB:  ctrl = CTRL_IDLE ^ (B_EO | B_AI | B_FI | B_SU);
            default: ctrl = CTRL_IDLE;
          endcase
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign step = cur_step;
  assign hlt  = clr_n && (halted_q || hlt_t2);
  assign mi_n = ctrl[C_MI];
  assign ri_n = ctrl[C_RI];
  assign ro_n = ctrl[C_RO];
  assign io_n = ctrl[C_IO];
  assign ii_n = ctrl[C_II];
  assign ai_n = ctrl[C_AI];
  assign ao_n = ctrl[C_AO];
  assign eo_n = ctrl[C_EO];
  assign su   = ctrl[C_SU];
  assign bi_n = ctrl[C_BI];
  assign oi_n = ctrl[C_OI];
  assign ce   = ctrl[C_CE];
  assign co_n = ctrl[C_CO];
  assign j_n  = ctrl[C_J];
  assign fi_n = ctrl[C_FI];

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer. Instance a uses EARLY_END=1 and
// instance b uses EARLY_END=0. Both share the same inputs.
module tb_cpu_control_sequencer;

  // Bit positions in the observed 16-bit vector.
  localparam int V_MI = 15;
  localparam int V_RI = 14;
  localparam int V_RO = 13;
  localparam int V_IO = 12;
  localparam int V_II = 11;
  localparam int V_AI = 10;
  localparam int V_AO = 9;
  localparam int V_EO = 8;
  localparam int V_SU = 7;
  localparam int V_BI = 6;
  localparam int V_OI = 5;
  localparam int V_CE = 4;
  localparam int V_CO = 3;
  localparam int V_J  = 2;
  localparam int V_FI = 1;
  localparam int V_HLT = 0;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       step_en;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;

  logic [2:0] a_step;
  logic a_hlt, a_mi_n, a_ri_n, a_ro_n, a_io_n, a_ii_n, a_ai_n, a_ao_n;
  logic a_eo_n, a_su, a_bi_n, a_oi_n, a_ce, a_co_n, a_j_n, a_fi_n;
  logic [2:0] b_step;
  logic b_hlt, b_mi_n, b_ri_n, b_ro_n, b_io_n, b_ii_n, b_ai_n, b_ao_n;
  logic b_eo_n, b_su, b_bi_n, b_oi_n, b_ce, b_co_n, b_j_n, b_fi_n;

  int total = 0;
  int bad   = 0;

  // Reference model state: the expected T-state and halt flag of each instance.
  int ma_t = 0;
  bit ma_h = 1'b0;
  int mb_t = 0;
  bit mb_h = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cpu_control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut_a (
    .clk(clk), .clr_n(clr_n), .step_en(step_en), .opcode(opcode),
    .carry(carry), .zero(zero), .step(a_step), .hlt(a_hlt),
    .mi_n(a_mi_n), .ri_n(a_ri_n), .ro_n(a_ro_n), .io_n(a_io_n),
    .ii_n(a_ii_n), .ai_n(a_ai_n), .ao_n(a_ao_n), .eo_n(a_eo_n),
    .su(a_su), .bi_n(a_bi_n), .oi_n(a_oi_n), .ce(a_ce), .co_n(a_co_n),
    .j_n(a_j_n), .fi_n(a_fi_n)
  );

  cpu_control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut_b (
    .clk(clk), .clr_n(clr_n), .step_en(step_en), .opcode(opcode),
    .carry(carry), .zero(zero), .step(b_step), .hlt(b_hlt),
    .mi_n(b_mi_n), .ri_n(b_ri_n), .ro_n(b_ro_n), .io_n(b_io_n),
    .ii_n(b_ii_n), .ai_n(b_ai_n), .ao_n(b_ao_n), .eo_n(b_eo_n),
    .su(b_su), .bi_n(b_bi_n), .oi_n(b_oi_n), .ce(b_ce), .co_n(b_co_n),
    .j_n(b_j_n), .fi_n(b_fi_n)
  );

  function automatic logic [15:0] vec_a();
    return {a_mi_n, a_ri_n, a_ro_n, a_io_n, a_ii_n, a_ai_n, a_ao_n, a_eo_n,
            a_su, a_bi_n, a_oi_n, a_ce, a_co_n, a_j_n, a_fi_n, a_hlt};
  endfunction

  function automatic logic [15:0] vec_b();
    return {b_mi_n, b_ri_n, b_ro_n, b_io_n, b_ii_n, b_ai_n, b_ao_n, b_eo_n,
            b_su, b_bi_n, b_oi_n, b_ce, b_co_n, b_j_n, b_fi_n, b_hlt};
  endfunction

  // ---------------- reference model ----------------
  // Each opcode's microstep table, written as lists of asserted strobes.
  function automatic logic [15:0] exp_vec(input logic [3:0] op, input int t,
                                          input logic c, input logic z,
                                          input logic rst_n, input bit halted);
    logic [15:0] v;
    v = '1;
    v[V_SU] = 1'b0;
    v[V_CE] = 1'b0;
    v[V_HLT] = 1'b0;
    if (!rst_n) return v;
    if (halted) begin
      v[V_HLT] = 1'b1;
      return v;
    end
    case (t)
      0: begin v[V_CO] = 1'b0; v[V_MI] = 1'b0; end
      1: begin v[V_RO] = 1'b0; v[V_II] = 1'b0; v[V_CE] = 1'b1; end
      2: begin
        case (op)
          4'd1, 4'd2, 4'd3, 4'd4: begin v[V_IO] = 1'b0; v[V_MI] = 1'b0; end
          4'd5: begin v[V_IO] = 1'b0; v[V_AI] = 1'b0; end
          4'd6: begin v[V_IO] = 1'b0; v[V_J] = 1'b0; end
          4'd7: if (c) begin v[V_IO] = 1'b0; v[V_J] = 1'b0; end
          4'd8: if (z) begin v[V_IO] = 1'b0; v[V_J] = 1'b0; end
          4'd14: begin v[V_AO] = 1'b0; v[V_OI] = 1'b0; end
          4'd15: v[V_HLT] = 1'b1;
          default: ;
        endcase
      end
      3: begin
        case (op)
          4'd1: begin v[V_RO] = 1'b0; v[V_AI] = 1'b0; end
          4'd2, 4'd3: begin v[V_RO] = 1'b0; v[V_BI] = 1'b0; end
          4'd4: begin v[V_AO] = 1'b0; v[V_RI] = 1'b0; end
          default: ;
        endcase
      end
      4: begin
        if (op == 4'd2 || op == 4'd3) begin
          v[V_EO] = 1'b0; v[V_AI] = 1'b0; v[V_FI] = 1'b0;
          if (op == 4'd3) v[V_SU] = 1'b1;
        end
      end
      default: ;
    endcase
    return v;
  endfunction

  // Instruction length in cycles. Without early end, every instruction takes all five steps.
  function automatic int instr_len(input logic [3:0] op, input bit early);
    if (!early) return 5;
    case (op)
      4'd1, 4'd4: return 4;
      4'd2, 4'd3: return 5;
      default:    return 3;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock. The model steps on the inputs seen at the edge.
  // The task returns 1 time unit after the edge, where the next inputs are driven.
  task automatic cycle();
    @(posedge clk);
    if (clr_n && step_en) begin
      if (!ma_h) begin
        if (ma_t == 2 && opcode == 4'hF) ma_h = 1'b1;
        else ma_t = (ma_t + 1 >= instr_len(opcode, 1'b1)) ? 0 : ma_t + 1;
      end
      if (!mb_h) begin
        if (mb_t == 2 && opcode == 4'hF) mb_h = 1'b1;
        else mb_t = (mb_t + 1 >= instr_len(opcode, 1'b0)) ? 0 : mb_t + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    ma_t = 0; ma_h = 1'b0; mb_t = 0; mb_h = 1'b0;
    cycle();
    clr_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_n = 1'b0; step_en = 1'b1; opcode = 4'h1; carry = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (vec_a() !== 16'hFF6E || a_step !== 3'd0 || a_hlt !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle step=%0d word=%h exp step=0 word=ff6e", a_step, vec_a());
      end
      cycle();
    end
    clr_n = 1'b1;
    #1;
    total++;
    if (a_co_n !== 1'b0 || a_mi_n !== 1'b0 || vec_a() !== exp_vec(4'h1, 0, 0, 0, 1, 0)) begin
      bad++;
      $display("FAIL reset_release_t0 word=%h exp=%h", vec_a(), exp_vec(4'h1, 0, 0, 0, 1, 0));
    end
  endtask

  // Runs one instruction from T0 with step_en=1, checks every step, and then checks the return to T0.
  task automatic test_instr(input string name, input logic [3:0] op,
                            input logic c, input logic z);
    logic [15:0] e;
    opcode = op; carry = c; zero = z; step_en = 1'b1;
    for (int s = 0; s < instr_len(op, 1'b1); s++) begin
      #1;
      e = exp_vec(op, s, c, z, 1'b1, 1'b0);
      total++;
      if (vec_a() !== e || a_step !== 3'(s)) begin
        bad++;
        $display("FAIL %s_t%0d step=%0d word=%h exp step=%0d word=%h", name, s, a_step, vec_a(), s, e);
      end
      cycle();
    end
    #1;
    total++;
    if (a_step !== 3'd0) begin
      bad++;
      $display("FAIL %s_end step=%0d exp=0", name, a_step);
    end
  endtask

  task automatic test_sub_t4();
    opcode = 4'h3; step_en = 1'b1;
    for (int s = 0; s < 4; s++) cycle();
    #1;
    total++;
    if ({a_eo_n, a_ai_n, a_fi_n, a_su} !== 4'b0001 || a_step !== 3'd4) begin
      bad++;
      $display("FAIL sub_t4 step=%0d eo/ai/fi/su=%b exp step=4 0001", a_step, {a_eo_n, a_ai_n, a_fi_n, a_su});
    end
    cycle();
    #1;
    total++;
    if (a_step !== 3'd0) begin
      bad++;
      $display("FAIL sub_end step=%0d exp=0", a_step);
    end
  endtask

  task automatic test_jc();
    for (int k = 0; k < 2; k++) begin
      opcode = 4'h7; carry = k[0]; zero = 1'b0; step_en = 1'b1;
      cycle(); cycle();
      #1;
      total++;
      if (a_step !== 3'd2 || a_j_n !== ~k[0] || a_io_n !== ~k[0]) begin
        bad++;
        $display("FAIL jc_c%0d_t2 step=%0d j_n=%b io_n=%b exp step=2 j_n=%b", k, a_step, a_j_n, a_io_n, ~k[0]);
      end
      cycle();
    end
  endtask

  task automatic test_hlt();
    opcode = 4'hF; step_en = 1'b1;
    cycle(); cycle();
    #1;
    total++;
    if (a_hlt !== 1'b1 || a_step !== 3'd2) begin
      bad++;
      $display("FAIL hlt_t2 hlt=%b step=%0d exp 1/2", a_hlt, a_step);
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      opcode = 4'($urandom_range(0, 15));
      #1;
      total++;
      if (a_hlt !== 1'b1 || a_step !== 3'd2 || vec_a() !== exp_vec(opcode, ma_t, 0, 0, 1, ma_h)) begin
        bad++;
        $display("FAIL hlt_hold%0d hlt=%b step=%0d word=%h", i, a_hlt, a_step, vec_a());
      end
    end
    #2;
    clr_n = 1'b0;
    ma_t = 0; ma_h = 1'b0; mb_t = 0; mb_h = 1'b0;
    #1;
    total++;
    if (a_hlt !== 1'b0 || a_step !== 3'd0 || b_hlt !== 1'b0) begin
      bad++;
      $display("FAIL hlt_async_clr hlt=%b step=%0d exp 0/0", a_hlt, a_step);
    end
    cycle();
    clr_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    opcode = 4'h2; step_en = 1'b1;
    cycle(); cycle(); cycle();
    #2;
    clr_n = 1'b0;
    ma_t = 0; ma_h = 1'b0; mb_t = 0; mb_h = 1'b0;
    #1;
    total++;
    if (a_bi_n !== 1'b1 || a_ro_n !== 1'b1 || vec_a() !== 16'hFF6E || a_step !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_idle word=%h step=%0d exp ff6e/0", vec_a(), a_step);
    end
    cycle();
    clr_n = 1'b1;
    #1;
    total++;
    if (vec_a() !== exp_vec(4'h2, 0, 0, 0, 1, 0)) begin
      bad++;
      $display("FAIL reset_mid_t0 word=%h exp=%h", vec_a(), exp_vec(4'h2, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_hold();
    opcode = 4'h4; step_en = 1'b1;
    cycle(); cycle(); cycle();
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      #1;
      total++;
      if (a_step !== 3'd3 || a_ao_n !== 1'b0 || a_ri_n !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d step=%0d ao_n=%b ri_n=%b exp 3/0/0", i, a_step, a_ao_n, a_ri_n);
      end
    end
    step_en = 1'b1;
    cycle();
    #1;
    total++;
    if (a_step !== 3'd0) begin
      bad++;
      $display("FAIL hold_end step=%0d exp=0", a_step);
    end
  endtask

  task automatic test_no_early_end();
    do_reset();
    opcode = 4'h0; step_en = 1'b1;
    for (int s = 0; s < 6; s++) begin
      #1;
      total++;
      if (b_step !== 3'(s % 5) || vec_b() !== exp_vec(4'h0, s % 5, 0, 0, 1, 0)) begin
        bad++;
        $display("FAIL noearly_nop%0d step=%0d word=%h exp step=%0d", s, b_step, vec_b(), s % 5);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    logic [15:0] ea;
    logic [15:0] eb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (ma_t == 0) begin
        opcode = 4'($urandom_range(0, 14));
        carry = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
      end
      step_en = ($urandom_range(0, 9) < 7);
      #1;
      ea = exp_vec(opcode, ma_t, carry, zero, 1'b1, ma_h);
      eb = exp_vec(opcode, mb_t, carry, zero, 1'b1, mb_h);
      total++;
      if (vec_a() !== ea || a_step !== 3'(ma_t) || vec_b() !== eb || b_step !== 3'(mb_t)) begin
        bad++;
        $display("FAIL rand%0d op=%h a:step=%0d word=%h exp %0d/%h b:step=%0d word=%h exp %0d/%h",
                 i, opcode, a_step, vec_a(), ma_t, ea, b_step, vec_b(), mb_t, eb);
      end
      cycle();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clr_n = 1'b0; step_en = 1'b0; opcode = 4'h0; carry = 1'b0; zero = 1'b0;
    cycle();
    test_reset();
    test_instr("lda", 4'h1, 1'b0, 1'b0);
    test_instr("sub", 4'h3, 1'b1, 1'b0);
    test_sub_t4();
    test_instr("nop", 4'h0, 1'b0, 1'b1);
    test_instr("ldi", 4'h5, 1'b0, 1'b0);
    test_instr("add", 4'h2, 1'b0, 1'b0);
    test_instr("jz_taken", 4'h8, 1'b0, 1'b1);
    test_instr("out", 4'hE, 1'b0, 1'b0);
    test_jc();
    test_hlt();
    test_reset_mid();
    test_hold();
    test_no_early_end();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
